// File: rtl/osc_meas_sched.sv
// Ring-oscillator measurement sequencer: clears, gates, latches and frames NUM_CH counts
// for the UART, then halts the oscillators after every STP_SMPL frames.
module osc_meas_sched #(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned GATE_CYCLES = 10000000,
   parameter int unsigned ACK_TIMEOUT = 64,
   parameter int unsigned STP_SMPL    = 30,
   parameter int unsigned HALT_CYCLES = 10000000
) (
   input  logic                   ref_clk,
   input  logic                   rstn,
   output logic                   osc_rst,
   output logic                   osc_halt,
   output logic                   osc_latch_req,
   input  logic [NUM_CH-1:0]      osc_latch_ack,
   input  logic [NUM_CH*32-1:0]   osc_counter_latch,
   output logic                   tx_start,
   output logic [NUM_CH*32-1:0]   tx_data,
   input  logic                   tx_busy,
   input  logic                   tx_done,
   output logic [NUM_CH-1:0]      ack_timeout,
   output logic [7:0]             sample_idx
);

   localparam logic [2:0] StClr    = 3'd0;
   localparam logic [2:0] StGate   = 3'd1;
   localparam logic [2:0] StLatch  = 3'd2;
   localparam logic [2:0] StAckLow = 3'd3;
   localparam logic [2:0] StSend   = 3'd4;
   localparam logic [2:0] StTxWait = 3'd5;
   localparam logic [2:0] StHalt   = 3'd6;

   localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int unsigned AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int unsigned HW = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;

   localparam logic [GW-1:0] GateLast = GW'(GATE_CYCLES - 1);
   localparam logic [AW-1:0] AckLast  = AW'(ACK_TIMEOUT - 1);
   localparam logic [HW-1:0] HaltLast = HW'(HALT_CYCLES - 1);
   localparam logic [7:0]    SmplLast = 8'(STP_SMPL - 1);

   logic [2:0]            state_q, state_d;
   logic [GW-1:0]         gate_cnt_q, gate_cnt_d;
   logic [AW-1:0]         wait_cnt_q, wait_cnt_d;
   logic [HW-1:0]         halt_cnt_q, halt_cnt_d;
   logic [7:0]            sample_idx_d;
   logic [NUM_CH*32-1:0]  tx_data_d;
   logic [NUM_CH-1:0]     ack_timeout_d;
   logic                  tx_start_d;

   always_comb begin
      state_d       = state_q;
      gate_cnt_d    = gate_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      halt_cnt_d    = halt_cnt_q;
      sample_idx_d  = sample_idx;
      tx_data_d     = tx_data;
      ack_timeout_d = ack_timeout;
      tx_start_d    = 1'b0;
      case (state_q)
         StClr: begin
            state_d    = StGate;
            gate_cnt_d = '0;
         end
         StGate: begin
            if (gate_cnt_q == GateLast) begin
               state_d    = StLatch;
               wait_cnt_d = '0;
            end else begin
               gate_cnt_d = gate_cnt_q + 1'b1;
            end
         end
         StLatch: begin
            // An ack present on the timeout cycle still counts as acked.
            if ((&osc_latch_ack) || (wait_cnt_q == AckLast)) begin
               for (int unsigned k = 0; k < NUM_CH; k++) begin
                  tx_data_d[32*k +: 32] = osc_latch_ack[k] ? osc_counter_latch[32*k +: 32]
                                                           : 32'hFFFF_FFFF;
               end
               ack_timeout_d = ~osc_latch_ack;
               state_d       = StAckLow;
               wait_cnt_d    = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         StAckLow: begin
            if (!(|osc_latch_ack) || (wait_cnt_q == AckLast)) begin
               state_d = StSend;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         StSend: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               state_d    = StTxWait;
            end
         end
         StTxWait: begin
            if (tx_done) begin
               if (sample_idx == SmplLast) begin
                  sample_idx_d = '0;
                  halt_cnt_d   = '0;
                  state_d      = StHalt;
               end else begin
                  sample_idx_d = sample_idx + 1'b1;
                  state_d      = StClr;
               end
            end
         end
         StHalt: begin
            if (halt_cnt_q == HaltLast) begin
               ack_timeout_d = '0;
               state_d       = StClr;
            end else begin
               halt_cnt_d = halt_cnt_q + 1'b1;
            end
         end
         default: state_d = StClr;
      endcase
   end

   // Control outputs are decoded from the next state so they stay registered yet aligned.
   always_ff @(posedge ref_clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= StClr;
         gate_cnt_q    <= '0;
         wait_cnt_q    <= '0;
         halt_cnt_q    <= '0;
         osc_rst       <= 1'b1;
         osc_halt      <= 1'b0;
         osc_latch_req <= 1'b0;
         tx_start      <= 1'b0;
         tx_data       <= '0;
         ack_timeout   <= '0;
         sample_idx    <= '0;
      end else begin
         state_q       <= state_d;
         gate_cnt_q    <= gate_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         halt_cnt_q    <= halt_cnt_d;
         osc_rst       <= (state_d == StClr) || (state_d == StHalt);
         osc_halt      <= (state_d == StHalt);
         osc_latch_req <= (state_d == StLatch);
         tx_start      <= tx_start_d;
         tx_data       <= tx_data_d;
         ack_timeout   <= ack_timeout_d;
         sample_idx    <= sample_idx_d;
      end
   end

endmodule

// File: tb/tb_osc_meas_sched.sv
// Bench for osc_meas_sched: randomized counts and ack delays, a behavioural ack responder
// and a frame-level expectation model.
module tb_osc_meas_sched;

   localparam int unsigned NumCh      = 2;
   localparam int unsigned GateCycles = 100;
   localparam int unsigned AckTimeout = 8;
   localparam int unsigned StpSmpl    = 3;
   localparam int unsigned HaltCycles = 50;

   logic               ref_clk = 1'b0;
   logic               rstn = 1'b0;
   logic               osc_rst, osc_halt, osc_latch_req, tx_start;
   logic [NumCh-1:0]   osc_latch_ack = '0;
   logic [63:0]        osc_counter_latch = '0;
   logic [63:0]        tx_data;
   logic               tx_busy = 1'b0;
   logic               tx_done = 1'b0;
   logic [NumCh-1:0]   ack_timeout;
   logic [7:0]         sample_idx;

   int n_checks = 0;
   int n_fail = 0;

   logic [15:0]        req_hist = '0;
   logic [NumCh-1:0]   ack_en = '1;
   int                 ack_dly [NumCh];

   osc_meas_sched #(
      .NUM_CH      (NumCh),
      .GATE_CYCLES (GateCycles),
      .ACK_TIMEOUT (AckTimeout),
      .STP_SMPL    (StpSmpl),
      .HALT_CYCLES (HaltCycles)
   ) dut (
      .ref_clk           (ref_clk),
      .rstn              (rstn),
      .osc_rst           (osc_rst),
      .osc_halt          (osc_halt),
      .osc_latch_req     (osc_latch_req),
      .osc_latch_ack     (osc_latch_ack),
      .osc_counter_latch (osc_counter_latch),
      .tx_start          (tx_start),
      .tx_data           (tx_data),
      .tx_busy           (tx_busy),
      .tx_done           (tx_done),
      .ack_timeout       (ack_timeout),
      .sample_idx        (sample_idx)
   );

   always #5 ref_clk = ~ref_clk;

   // Oscillator side: each enabled channel mirrors the request ack_dly cycles later.
   initial begin
      forever begin
         @(posedge ref_clk);
         #1;
         req_hist = {req_hist[14:0], osc_latch_req};
         for (int k = 0; k < NumCh; k++) osc_latch_ack[k] = ack_en[k] & req_hist[ack_dly[k]];
      end
   end

   function automatic logic [63:0] exp_frame(input logic [63:0] cnts, input logic [NumCh-1:0] en);
      logic [63:0] r;
      for (int k = 0; k < NumCh; k++) r[32*k +: 32] = en[k] ? cnts[32*k +: 32] : 32'hFFFF_FFFF;
      return r;
   endfunction

   function automatic int exp_req_len(input logic [NumCh-1:0] en);
      int m = 0;
      if (!(&en)) return AckTimeout;
      for (int k = 0; k < NumCh; k++) if (ack_dly[k] > m) m = ack_dly[k];
      return m + 1;
   endfunction

   task automatic randomize_frame(input logic [NumCh-1:0] en);
      ack_en = en;
      for (int k = 0; k < NumCh; k++) ack_dly[k] = $urandom_range(0, 4);
      osc_counter_latch = {$urandom, $urandom};
   endtask

   // Walks one frame from the current sample; done_dly < 0 stops at the tx_start pulse.
   task automatic run_frame(input int busy_cyc, input int done_dly, output bit ok,
         output int gate_len, output int req_len, output int nstart, output int b2s,
         output int start_at, output logic [63:0] d_start, output logic [63:0] d_done,
         output logic [NumCh-1:0] to_start, output logic [7:0] idx_after);
      int ph = 0;
      int busy_left = 0;
      int done_left = 0;
      bit started = 0;
      bit fin_next = 0;
      bit b2s_run = 0;
      ok = 0; gate_len = 0; req_len = 0; nstart = 0; b2s = 0; start_at = -1;
      d_start = '0; d_done = '0; to_start = '0; idx_after = '0;
      for (int n = 0; n < 2000; n++) begin
         if (tx_start) nstart++;
         if (fin_next) begin
            tx_done = 1'b0;
            idx_after = sample_idx;
            ok = 1;
            break;
         end
         case (ph)
            0: if (osc_rst) ph = 1;
            1: if (!osc_rst) begin ph = 2; gate_len = 1; end
            2: if (osc_latch_req) begin
                  ph = 3;
                  req_len = 1;
                  if (busy_cyc > 0) begin tx_busy = 1'b1; busy_left = busy_cyc + 1; end
               end else gate_len++;
            3: if (osc_latch_req) req_len++; else ph = 4;
            default: ;
         endcase
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin tx_busy = 1'b0; b2s_run = 1; end
         end else if (b2s_run && !started) b2s++;
         if (tx_start && !started) begin
            started = 1;
            start_at = n;
            d_start = tx_data;
            to_start = ack_timeout;
            done_left = done_dly;
            if (done_dly < 0) begin ok = 1; break; end
         end
         if (started && !fin_next) begin
            if (done_left == 0) begin tx_done = 1'b1; d_done = tx_data; fin_next = 1; end
            else done_left--;
         end
         @(posedge ref_clk);
         #2;
      end
      tx_busy = 1'b0;
      tx_done = 1'b0;
   endtask

   bit ok;
   int gate_len, req_len, nstart, b2s, start_at;
   logic [63:0] d_start, d_done, exp_d;
   logic [NumCh-1:0] to_start;
   logic [7:0] idx_after;

   task automatic check_reset_values(input string tag);
      n_checks++; if (osc_rst !== 1'b1) begin n_fail++; $display("FAIL %s osc_rst: got %b want 1", tag, osc_rst); end
      n_checks++; if (osc_halt !== 1'b0) begin n_fail++; $display("FAIL %s osc_halt: got %b want 0", tag, osc_halt); end
      n_checks++; if (osc_latch_req !== 1'b0) begin n_fail++; $display("FAIL %s latch_req: got %b want 0", tag, osc_latch_req); end
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL %s tx_start: got %b want 0", tag, tx_start); end
      n_checks++; if (tx_data !== 64'h0) begin n_fail++; $display("FAIL %s tx_data: got %h want 0", tag, tx_data); end
      n_checks++; if (ack_timeout !== '0) begin n_fail++; $display("FAIL %s ack_timeout: got %b want 0", tag, ack_timeout); end
      n_checks++; if (sample_idx !== 8'd0) begin n_fail++; $display("FAIL %s sample_idx: got %0d want 0", tag, sample_idx); end
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      #12;
      check_reset_values("reset");
      @(negedge ref_clk);
      rstn = 1'b1;
   endtask

   task automatic test_nominal;
      ack_en = '1;
      ack_dly[0] = 2;
      ack_dly[1] = 2;
      osc_counter_latch = {32'h22, 32'h11};
      run_frame(0, 3, ok, gate_len, req_len, nstart, b2s, start_at, d_start, d_done, to_start, idx_after);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL nominal_complete: got 0 want 1"); end
      n_checks++; if (gate_len != GateCycles) begin n_fail++; $display("FAIL nominal_gate_len: got %0d want %0d", gate_len, GateCycles); end
      n_checks++; if (req_len != 3) begin n_fail++; $display("FAIL nominal_req_len: got %0d want 3", req_len); end
      n_checks++; if (nstart != 1) begin n_fail++; $display("FAIL nominal_tx_start_pulses: got %0d want 1", nstart); end
      n_checks++; if (d_start !== 64'h00000022_00000011) begin n_fail++; $display("FAIL nominal_tx_data: got %h want 0000002200000011", d_start); end
      n_checks++; if (d_done !== 64'h00000022_00000011) begin n_fail++; $display("FAIL nominal_tx_data_at_done: got %h want 0000002200000011", d_done); end
      n_checks++; if (to_start !== 2'b00) begin n_fail++; $display("FAIL nominal_ack_timeout: got %b want 00", to_start); end
      n_checks++; if (idx_after !== 8'd1) begin n_fail++; $display("FAIL nominal_sample_idx: got %0d want 1", idx_after); end
   endtask

   task automatic test_timeout;
      randomize_frame(2'b01);
      exp_d = exp_frame(osc_counter_latch, ack_en);
      run_frame(0, $urandom_range(1, 5), ok, gate_len, req_len, nstart, b2s, start_at, d_start, d_done, to_start, idx_after);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout_complete: got 0 want 1"); end
      n_checks++; if (req_len != AckTimeout) begin n_fail++; $display("FAIL timeout_req_len: got %0d want %0d", req_len, AckTimeout); end
      n_checks++; if (to_start !== 2'b10) begin n_fail++; $display("FAIL timeout_flags: got %b want 10", to_start); end
      n_checks++; if (d_start !== exp_d) begin n_fail++; $display("FAIL timeout_tx_data: got %h want %h", d_start, exp_d); end
      n_checks++; if (nstart != 1) begin n_fail++; $display("FAIL timeout_tx_start_pulses: got %0d want 1", nstart); end
      n_checks++; if (idx_after !== 8'd2) begin n_fail++; $display("FAIL timeout_sample_idx: got %0d want 2", idx_after); end
   endtask

   task automatic test_busy_stall;
      randomize_frame(2'b10);
      exp_d = exp_frame(osc_counter_latch, ack_en);
      run_frame(40, 6, ok, gate_len, req_len, nstart, b2s, start_at, d_start, d_done, to_start, idx_after);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_complete: got 0 want 1"); end
      n_checks++; if (b2s != 1) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 1", b2s); end
      n_checks++; if (nstart != 1) begin n_fail++; $display("FAIL busy_tx_start_pulses: got %0d want 1", nstart); end
      n_checks++; if (d_start !== exp_d) begin n_fail++; $display("FAIL busy_tx_data: got %h want %h", d_start, exp_d); end
      n_checks++; if (d_done !== exp_d) begin n_fail++; $display("FAIL busy_tx_data_at_done: got %h want %h", d_done, exp_d); end
      n_checks++; if (to_start !== 2'b01) begin n_fail++; $display("FAIL busy_flags: got %b want 01", to_start); end
      n_checks++; if (idx_after !== 8'd0) begin n_fail++; $display("FAIL busy_sample_idx_wrap: got %0d want 0", idx_after); end
   endtask

   task automatic test_halt;
      int hl = 0;
      int rl = 0;
      n_checks++; if (ack_timeout !== 2'b01) begin n_fail++; $display("FAIL halt_flags_held: got %b want 01", ack_timeout); end
      for (int n = 0; n < 200; n++) begin
         if (!osc_halt) break;
         hl++;
         if (osc_rst) rl++;
         @(posedge ref_clk);
         #2;
      end
      n_checks++; if (hl != HaltCycles) begin n_fail++; $display("FAIL halt_len: got %0d want %0d", hl, HaltCycles); end
      n_checks++; if (rl != HaltCycles) begin n_fail++; $display("FAIL halt_osc_rst_len: got %0d want %0d", rl, HaltCycles); end
      n_checks++; if (osc_rst !== 1'b1) begin n_fail++; $display("FAIL halt_clr_after: got %b want 1", osc_rst); end
      n_checks++; if (ack_timeout !== 2'b00) begin n_fail++; $display("FAIL halt_flags_cleared: got %b want 00", ack_timeout); end
      n_checks++; if (sample_idx !== 8'd0) begin n_fail++; $display("FAIL halt_sample_idx: got %0d want 0", sample_idx); end
      randomize_frame(2'b11);
      exp_d = exp_frame(osc_counter_latch, ack_en);
      run_frame(0, 2, ok, gate_len, req_len, nstart, b2s, start_at, d_start, d_done, to_start, idx_after);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL frame4_complete: got 0 want 1"); end
      n_checks++; if (gate_len != GateCycles) begin n_fail++; $display("FAIL frame4_gate_len: got %0d want %0d", gate_len, GateCycles); end
      n_checks++; if (req_len != exp_req_len(ack_en)) begin n_fail++; $display("FAIL frame4_req_len: got %0d want %0d", req_len, exp_req_len(ack_en)); end
      n_checks++; if (d_start !== exp_d) begin n_fail++; $display("FAIL frame4_tx_data: got %h want %h", d_start, exp_d); end
      n_checks++; if (idx_after !== 8'd1) begin n_fail++; $display("FAIL frame4_sample_idx: got %0d want 1", idx_after); end
   endtask

   task automatic test_async_reset;
      // Mid-gate: run well into the window, then drop rstn between clock edges.
      for (int n = 0; n < 20; n++) begin
         if (!osc_rst) break;
         @(posedge ref_clk);
         #2;
      end
      repeat (30) begin @(posedge ref_clk); #2; end
      #3;
      rstn = 1'b0;
      #1;
      check_reset_values("rst_mid_gate");
      @(negedge ref_clk);
      rstn = 1'b1;
      randomize_frame(2'b11);
      exp_d = exp_frame(osc_counter_latch, ack_en);
      run_frame(0, 2, ok, gate_len, req_len, nstart, b2s, start_at, d_start, d_done, to_start, idx_after);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rst1_complete: got 0 want 1"); end
      n_checks++; if (gate_len != GateCycles) begin n_fail++; $display("FAIL rst1_gate_len: got %0d want %0d", gate_len, GateCycles); end
      n_checks++; if (start_at <= int'(GateCycles) + 1) begin n_fail++; $display("FAIL rst1_start_time: got %0d want >%0d", start_at, GateCycles + 1); end
      n_checks++; if (nstart != 1) begin n_fail++; $display("FAIL rst1_tx_start_pulses: got %0d want 1", nstart); end
      n_checks++; if (d_start !== exp_d) begin n_fail++; $display("FAIL rst1_tx_data: got %h want %h", d_start, exp_d); end
      n_checks++; if (idx_after !== 8'd1) begin n_fail++; $display("FAIL rst1_sample_idx: got %0d want 1", idx_after); end
      // Mid-TXWAIT: abandon a frame after its start pulse.
      randomize_frame(2'b11);
      run_frame(0, -1, ok, gate_len, req_len, nstart, b2s, start_at, d_start, d_done, to_start, idx_after);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rst2_reach_txwait: got 0 want 1"); end
      repeat (3) begin @(posedge ref_clk); #2; end
      #3;
      rstn = 1'b0;
      #1;
      check_reset_values("rst_mid_txwait");
      @(negedge ref_clk);
      rstn = 1'b1;
      randomize_frame(2'b11);
      exp_d = exp_frame(osc_counter_latch, ack_en);
      run_frame(0, 2, ok, gate_len, req_len, nstart, b2s, start_at, d_start, d_done, to_start, idx_after);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rst2_complete: got 0 want 1"); end
      n_checks++; if (gate_len != GateCycles) begin n_fail++; $display("FAIL rst2_gate_len: got %0d want %0d", gate_len, GateCycles); end
      n_checks++; if (start_at <= int'(GateCycles) + 1) begin n_fail++; $display("FAIL rst2_start_time: got %0d want >%0d", start_at, GateCycles + 1); end
      n_checks++; if (nstart != 1) begin n_fail++; $display("FAIL rst2_tx_start_pulses: got %0d want 1", nstart); end
      n_checks++; if (d_start !== exp_d) begin n_fail++; $display("FAIL rst2_tx_data: got %h want %h", d_start, exp_d); end
      n_checks++; if (idx_after !== 8'd1) begin n_fail++; $display("FAIL rst2_sample_idx: got %0d want 1", idx_after); end
   endtask

   initial begin
      ack_dly[0] = 2;
      ack_dly[1] = 2;
      test_reset();
      test_nominal();
      test_timeout();
      test_busy_stall();
      test_halt();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/osc_meas_sched.md
Name: osc_meas_sched

Overview:
- Measurement sequencer for the GPIO ring-oscillator stress test.
- Drives the shared reset/halt/latch controls of NUM_CH osc counter instances and times the gate window from ref_clk.
- Collects the latched counts, with per-channel ack timeout, and hands a packed frame to the uart_tx instance.
- After STP_SMPL frames it holds the oscillators halted for HALT_CYCLES, then restarts.

Parameters:
- NUM_CH, 2, number of oscillator channels (1..8).
- GATE_CYCLES, 10000000, gate window length in ref_clk cycles (>=2).
- ACK_TIMEOUT, 64, max cycles waiting for all latch acks (>=1).
- STP_SMPL, 30, frames per run before halt (>=1).
- HALT_CYCLES, 10000000, halt duration in ref_clk cycles (>=1).

Ports:
- ref_clk, in, 1, sole clock.
- rstn, in, 1, asynchronous active-low reset.
- osc_rst, out, 1, clears oscillator counters.
- osc_halt, out, 1, stops all oscillators.
- osc_latch_req, out, 1, level request to latch counters.
- osc_latch_ack, in, NUM_CH, per-channel latch acknowledge (level).
- osc_counter_latch, in, NUM_CH*32, latched counts; channel k at [32k+31:32k].
- tx_start, out, 1, one-cycle frame start pulse to uart_tx.
- tx_data, out, NUM_CH*32, frame payload; stable from tx_start until tx_done.
- tx_busy, in, 1, uart busy.
- tx_done, in, 1, uart frame complete pulse.
- ack_timeout, out, NUM_CH, sticky-per-frame flag: channel did not ack.
- sample_idx, out, 8, frames sent in current run (0..STP_SMPL-1).

Behaviour:
- Reset (rstn=0, async):
  - state=CLR; osc_rst=1, osc_halt=0, osc_latch_req=0, tx_start=0.
  - tx_data=0, ack_timeout=0, sample_idx=0, all counters 0.
- All outputs are registered; no combinational input-to-output paths.
- CLR: osc_rst=1 for exactly 1 cycle, then GATE.
- GATE:
  - osc_rst=0; gate_cnt counts 0..GATE_CYCLES-1, so the window is exactly GATE_CYCLES cycles.
  - On the last count go to LATCH with osc_latch_req=1 on the next cycle.
- LATCH:
  - osc_latch_req held 1; wait_cnt increments each cycle.
  - Exit when &osc_latch_ack=1, or when wait_cnt reaches ACK_TIMEOUT-1.
  - On exit:
    - capture osc_counter_latch into tx_data.
    - ack_timeout[k] = ~osc_latch_ack[k] at the exit cycle.
    - timed-out channels carry 32'hFFFFFFFF in tx_data.
    - drop osc_latch_req; go to ACKLOW.
  - Acks arriving on the timeout cycle count as acked (ack wins).
- ACKLOW:
  - wait until all acks are 0 (4-phase handshake), bounded by ACK_TIMEOUT cycles; then SEND.
  - A stuck-high ack does not set a flag here.
- SEND:
  - when tx_busy=0, pulse tx_start for 1 cycle, go to TXWAIT.
  - if tx_busy=1, wait without limit.
- TXWAIT:
  - on tx_done=1, increment sample_idx.
  - if sample_idx was STP_SMPL-1: sample_idx<=0, go to HALT.
  - else go to CLR.
  - tx_done seen outside TXWAIT is ignored.
- HALT:
  - osc_halt=1, osc_rst=1; halt_cnt counts HALT_CYCLES cycles.
  - then osc_halt=0, ack_timeout cleared, go to CLR.
- Oscillators free-run during SEND/TXWAIT; the next gate starts only after CLR.
- Frame period (no stalls, immediate acks) = 1 (CLR) + GATE_CYCLES + latch/ack latency + UART time.
- All counters are sized with $clog2 of their bound; none wraps, each is reset on state entry.
- Reset mid-operation: immediate return to the reset values.
  - A frame in flight is abandoned; tx_start is never re-pulsed spuriously.
  - The oscillators come out of reset cleared (osc_rst=1).

Test Plan:
- Bench params: NUM_CH=2, GATE_CYCLES=100, ACK_TIMEOUT=8, STP_SMPL=3, HALT_CYCLES=50.
- Nominal: acks rise 2 cycles after req, counts 0x11/0x22 -> osc_latch_req asserted exactly 100 cycles after osc_rst falls; tx_data=0x00000022_00000011; one tx_start pulse; ack_timeout=00.
- Timeout: channel 1 never acks -> req drops 8 cycles after rising; ack_timeout=10; tx_data[63:32]=FFFFFFFF, [31:0]=captured ch0 count.
- Busy stall: tx_busy=1 for 40 cycles after LATCH -> tx_start fires on the first cycle tx_busy=0; tx_data unchanged until tx_done.
- Halt cycle: run 3 frames -> after third tx_done, osc_halt=1 for exactly 50 cycles; sample_idx returns 0; fourth gate starts after CLR.
- Async reset: drop rstn mid-GATE and mid-TXWAIT -> outputs reach reset values without a clock edge; after release, the first tx_start occurs only after a full new gate.
